mux4_scan_ctrl: RTL and testbench

Sequential scan controller that sits directly upstream of the `mux4_1` selector. It drives the 2-bit select, steps it through channels 0..3 with a programmable settle time, and samples the mux output on each channel. It then publishes the four sampled bits as one word with a done pulse. Used in the P1 datapath wherever four single-bit sources are read through one `mux4_1`.

---
 rtl/mux4_scan_ctrl_pkg.sv | 29 ++
 rtl/mux4_scan_ctrl_if.sv | 32 +++
 rtl/mux4_1.sv | 26 ++
 rtl/mux4_scan_ctrl_dwell_cnt.sv | 40 ++++
 rtl/mux4_scan_ctrl.sv | 115 +++++++++++
 tb/tb_mux4_scan_ctrl.sv | 273 +++++++++++++++++++++++++++
 6 files changed

// File: rtl/mux4_scan_ctrl_pkg.sv
// ----------------------------------------------------------------------------
// mux4_scan_ctrl_pkg
// Shared definitions for the 4-channel scan controller.
//   - state_e : controller states (IDLE / SETTLE / DONE)
//   - CH_A..CH_D : select codes driven to mux4_1 (code = channel index)
//   - CNT_W : width of the dwell counter
//   - scan_req() : condition that launches a scan from IDLE or DONE
// ----------------------------------------------------------------------------
package mux4_scan_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_DONE   = 2'd2
    } state_e;

    localparam logic [1:0] CH_A = 2'd0;
    localparam logic [1:0] CH_B = 2'd1;
    localparam logic [1:0] CH_C = 2'd2;
    localparam logic [1:0] CH_D = 2'd3;

    localparam int CNT_W = 4;

    // A scan is launched by an explicit request or by continuous mode.
    function automatic logic scan_req(input logic start, input logic cont);
        return start | cont;
    endfunction

endpackage

// File: rtl/mux4_scan_ctrl_if.sv
// ----------------------------------------------------------------------------
// mux4_scan_ctrl_if
// Bundle between a scan requester (master) and the scan controller (slave).
//   start   : request one scan
//   cont    : continuous scanning
//   mux_out : output of the mux4_1 being scanned
//   s       : select driven to mux4_1
//   busy    : scan in progress
//   done    : one-cycle pulse, data just updated
//   data    : last complete scan, data[i] = sample of channel i
// ----------------------------------------------------------------------------
interface mux4_scan_ctrl_if;

    logic       start;
    logic       cont;
    logic       mux_out;
    logic [1:0] s;
    logic       busy;
    logic       done;
    logic [3:0] data;

    modport master (
        output start, cont, mux_out,
        input  s, busy, done, data
    );

    modport slave (
        input  start, cont, mux_out,
        output s, busy, done, data
    );

endinterface

// File: rtl/mux4_1.sv
// ----------------------------------------------------------------------------
// mux4_1
// Purely combinational 4:1 single-bit selector.
//   a,b,c,d : channel inputs (select codes 00,01,10,11)
//   s       : select
//   out     : selected channel
// ----------------------------------------------------------------------------
module mux4_1 (
    output logic       out,
    input  logic       a,
    input  logic       b,
    input  logic       c,
    input  logic       d,
    input  logic [1:0] s
);

    always_comb begin
        unique case (s)
            2'd0:    out = a;
            2'd1:    out = b;
            2'd2:    out = c;
            default: out = d;
        endcase
    end

endmodule

// File: rtl/mux4_scan_ctrl_dwell_cnt.sv
// ----------------------------------------------------------------------------
// dwell_cnt
// Settle-time counter for the scan controller. Counts 0..DWELL-1 and wraps;
// held at zero while i_clr is high.
//   clk, reset : clock, synchronous active-high reset
//   i_clr      : synchronous clear (counter idles at 0)
//   o_tc       : terminal count, high while count == DWELL-1
// ----------------------------------------------------------------------------
module dwell_cnt
#(
    parameter int DWELL = 2
)
(
    input  logic clk,
    input  logic reset,
    input  logic i_clr,
    output logic o_tc
);

    import mux4_scan_ctrl_pkg::*;

    localparam logic [CNT_W-1:0] TC_VAL = CNT_W'(DWELL - 1);

    logic [CNT_W-1:0] r_cnt;

    // NOTE: sequential state uses non-blocking (<=) so every flop samples
    // pre-edge values regardless of process ordering.
    always_ff @(posedge clk) begin
        if (reset || i_clr) begin
            r_cnt <= '0;
        end else if (r_cnt == TC_VAL) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_tc = (r_cnt == TC_VAL);

endmodule

// File: rtl/mux4_scan_ctrl.sv
// ----------------------------------------------------------------------------
// mux4_scan_ctrl
// Steps the select of a mux4_1 through channels 0..3, holding each for DWELL
// cycles, samples mux_out at the end of each dwell and publishes the four
// bits as one word with a one-cycle done pulse.
//   DWELL : cycles per channel before sampling (1..15)
//   clk   : clock
//   reset : synchronous active-high reset
//   bus   : slave side of mux4_scan_ctrl_if (start, cont, mux_out in;
//           s, busy, done, data out)
// All outputs come from registers or from state decode only.
// ----------------------------------------------------------------------------
module mux4_scan_ctrl
#(
    parameter int DWELL = 2
)
(
    input  logic              clk,
    input  logic              reset,
    mux4_scan_ctrl_if.slave   bus
);

    import mux4_scan_ctrl_pkg::*;

    state_e     r_state;
    state_e     w_state_nxt;
    logic [1:0] r_s;
    logic [2:0] r_shadow;
    logic [3:0] r_data;

    logic       w_in_settle;
    logic       w_tc;
    logic       w_sample;
    logic       w_req;

    assign w_in_settle = (r_state == ST_SETTLE);
    assign w_sample    = w_in_settle && w_tc;
    assign w_req       = scan_req(bus.start, bus.cont);

    // Counter idles at zero outside SETTLE so every scan starts with cnt=0.
    dwell_cnt #(
        .DWELL (DWELL)
    ) u_dwell_cnt (
        .clk   (clk),
        .reset (reset),
        .i_clr (!w_in_settle),
        .o_tc  (w_tc)
    );

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // NOTE: next state defaults to the current state before the case, so
    // every path assigns it and no latch is inferred.
    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            ST_IDLE: begin
                if (w_req) begin
                    w_state_nxt = ST_SETTLE;
                end
            end
            ST_SETTLE: begin
                if (w_sample && (r_s == CH_D)) begin
                    w_state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                // start in SETTLE is never queued; only a request present
                // now in DONE chains a back-to-back scan.
                w_state_nxt = w_req ? ST_SETTLE : ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Select, shadow and published word
    // ------------------------------------------------------------------
    // NOTE: the shadow bits are reset along with everything else so that a
    // scan aborted by reset leaves no partial samples behind.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_s      <= CH_A;
            r_shadow <= '0;
            r_data   <= '0;
        end else if (w_sample) begin
            if (r_s == CH_D) begin
                // Last channel goes straight into the word; the partial
                // scan in the shadow is never visible on data.
                r_data <= {bus.mux_out, r_shadow};
                r_s    <= CH_A;
            end else begin
                r_shadow[r_s] <= bus.mux_out;
                r_s           <= r_s + 2'd1;
            end
        end
    end

    assign bus.s    = r_s;
    assign bus.busy = w_in_settle;
    assign bus.done = (r_state == ST_DONE);
    assign bus.data = r_data;

endmodule

// File: tb/tb_mux4_scan_ctrl.sv
// ----------------------------------------------------------------------------
// tb_mux4_scan_ctrl
// Two controllers (DWELL=2 and DWELL=1), each scanning its own mux4_1 fed
// from shared channel inputs a..d. A scan-level reference model tracks the
// elapsed cycles of the current scan and predicts s/busy/done/data; a
// monitor compares every cycle. Directed scenarios pin absolute values,
// then a randomized phase exercises start/cont/reset/inputs.
// ----------------------------------------------------------------------------
module tb_mux4_scan_ctrl;

    logic clk = 1'b0;
    logic reset;
    logic a, b, c, d;

    always #5 clk = ~clk;

    mux4_scan_ctrl_if bus_d2 ();
    mux4_scan_ctrl_if bus_d1 ();

    mux4_1 u_mux_d2 (.out(bus_d2.mux_out), .a(a), .b(b), .c(c), .d(d), .s(bus_d2.s));
    mux4_1 u_mux_d1 (.out(bus_d1.mux_out), .a(a), .b(b), .c(c), .d(d), .s(bus_d1.s));

    mux4_scan_ctrl #(.DWELL(2)) u_dut_d2 (.clk(clk), .reset(reset), .bus(bus_d2));
    mux4_scan_ctrl #(.DWELL(1)) u_dut_d1 (.clk(clk), .reset(reset), .bus(bus_d1));

    // ------------------------------------------------------------------
    // Bookkeeping
    // ------------------------------------------------------------------
    int n_vec  = 0;
    int n_miss = 0;
    int cyc    = 0;
    bit cmp_en = 1'b0;
    int done_cnt [2] = '{0, 0};
    int last_done[2] = '{0, 0};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [1:0] dut_s(input int k);
        return (k == 0) ? bus_d2.s : bus_d1.s;
    endfunction
    function automatic logic dut_busy(input int k);
        return (k == 0) ? bus_d2.busy : bus_d1.busy;
    endfunction
    function automatic logic dut_done(input int k);
        return (k == 0) ? bus_d2.done : bus_d1.done;
    endfunction
    function automatic logic [3:0] dut_data(input int k);
        return (k == 0) ? bus_d2.data : bus_d1.data;
    endfunction

    // ------------------------------------------------------------------
    // Reference model: pos = cycles elapsed in the current scan, -1 when
    // not scanning. Channel i is sampled when pos reaches (i+1)*DWELL;
    // the word is published when pos reaches 4*DWELL.
    // ------------------------------------------------------------------
    const int   dw[2] = '{2, 1};
    int         pos   [2];
    bit         m_done[2];
    logic [3:0] m_data[2];
    logic [3:0] m_samp[2];

    initial begin
        for (int k = 0; k < 2; k++) begin
            pos[k] = -1; m_done[k] = 1'b0; m_data[k] = '0; m_samp[k] = '0;
        end
    end

    function automatic void model_step(input int k, input logic req, input logic [3:0] ch);
        if (reset) begin
            pos[k] = -1; m_done[k] = 1'b0; m_data[k] = '0; m_samp[k] = '0;
        end else if (pos[k] >= 0) begin
            pos[k]++;
            m_done[k] = 1'b0;
            if (pos[k] % dw[k] == 0)
                m_samp[k][pos[k] / dw[k] - 1] = ch[pos[k] / dw[k] - 1];
            if (pos[k] == 4 * dw[k]) begin
                m_data[k] = m_samp[k];
                m_done[k] = 1'b1;
                pos[k]    = -1;
            end
        end else begin
            m_done[k] = 1'b0;
            if (req) pos[k] = 0;
        end
    endfunction

    function automatic logic [1:0] exp_s(input int k);
        if (pos[k] < 0) return 2'd0;
        return 2'(pos[k] / dw[k]);
    endfunction

    always @(posedge clk) begin
        cyc++;
        model_step(0, bus_d2.start | bus_d2.cont, {d, c, b, a});
        model_step(1, bus_d1.start | bus_d1.cont, {d, c, b, a});
    end

    // ------------------------------------------------------------------
    // Every-cycle compare, away from the active edge
    // ------------------------------------------------------------------
    always @(negedge clk) begin
        if (cmp_en) begin
            for (int k = 0; k < 2; k++) begin
                check($sformatf("s[d%0d]",    dw[k]), dut_s(k),    exp_s(k));
                check($sformatf("busy[d%0d]", dw[k]), dut_busy(k), pos[k] >= 0);
                check($sformatf("done[d%0d]", dw[k]), dut_done(k), m_done[k]);
                check($sformatf("data[d%0d]", dw[k]), dut_data(k), m_data[k]);
                if (dut_done(k) === 1'b1) begin
                    done_cnt[k]++;
                    last_done[k] = cyc;
                end
            end
        end
    end

    // Bounded wait for a done pulse; returns on the negedge where done is high.
    task automatic wait_done(input int k, input int max_cyc, input string name);
        int n = 0;
        while (dut_done(k) !== 1'b1 && n < max_cyc) begin
            @(negedge clk);
            n++;
        end
        check({name, "_in_time"}, n < max_cyc, 1'b1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, cyc=%0d", cyc);
        $fatal(1);
    end

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    initial begin
        int t0;
        int base;
        logic [1:0] s_seq [8];
        s_seq = '{2'd0, 2'd0, 2'd1, 2'd1, 2'd2, 2'd2, 2'd3, 2'd3};

        reset = 1'b1;
        {a, b, c, d} = 4'b0000;
        bus_d2.start = 1'b0; bus_d2.cont = 1'b0;
        bus_d1.start = 1'b0; bus_d1.cont = 1'b0;
        repeat (2) @(negedge clk);
        cmp_en = 1'b1;
        reset  = 1'b0;

        // Idle after reset: everything quiet.
        repeat (5) begin
            @(negedge clk);
            for (int k = 0; k < 2; k++) begin
                check("idle_s",    dut_s(k),    2'b00);
                check("idle_data", dut_data(k), 4'b0000);
                check("idle_busy", dut_busy(k), 1'b0);
                check("idle_done", dut_done(k), 1'b0);
            end
        end

        // DWELL=2 single scan, a=1 b=0 c=1 d=1.
        a = 1'b1; b = 1'b0; c = 1'b1; d = 1'b1;
        bus_d2.start = 1'b1;
        @(negedge clk);
        bus_d2.start = 1'b0;
        for (int k = 0; k < 8; k++) begin
            check($sformatf("scan_s_seq%0d", k), bus_d2.s, s_seq[k]);
            check($sformatf("scan_nodone%0d", k), bus_d2.done, 1'b0);
            @(negedge clk);
        end
        check("scan_done_t8", bus_d2.done, 1'b1);
        check("scan_data",    bus_d2.data, 4'b1101);
        @(negedge clk);
        check("scan_done_fall", bus_d2.done, 1'b0);

        // start pulsed mid-scan is ignored.
        bus_d2.start = 1'b1;
        @(negedge clk);
        bus_d2.start = 1'b0;
        t0   = cyc;
        base = done_cnt[0];
        repeat (3) @(negedge clk);
        bus_d2.start = 1'b1;
        @(negedge clk);
        bus_d2.start = 1'b0;
        repeat (12) @(negedge clk);
        check("ignore_one_done", done_cnt[0] - base, 1);
        check("ignore_latency",  last_done[0] - t0, 8);

        // DWELL=1 continuous mode, a=0 b=1 c=1 d=0.
        a = 1'b0; b = 1'b1; c = 1'b1; d = 1'b0;
        bus_d1.cont = 1'b1;
        wait_done(1, 20, "cont_first");
        check("cont_data0", bus_d1.data, 4'b0110);
        t0 = cyc;
        for (int r = 0; r < 2; r++) begin
            @(negedge clk);
            wait_done(1, 20, "cont_next");
            check("cont_data",   bus_d1.data, 4'b0110);
            check("cont_period", cyc - t0, 5);
            t0 = cyc;
        end
        d = 1'b1;
        @(negedge clk);
        wait_done(1, 20, "cont_dchg");
        check("cont_data_d1",   bus_d1.data, 4'b1110);
        check("cont_period_d1", cyc - t0, 5);
        bus_d1.cont = 1'b0;
        repeat (8) @(negedge clk);

        // Reset at t0+5 of a DWELL=2 scan aborts it cleanly.
        a = 1'b1; b = 1'b0; c = 1'b1; d = 1'b1;
        bus_d2.start = 1'b1;
        @(negedge clk);
        bus_d2.start = 1'b0;
        repeat (4) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("abort_s",    bus_d2.s,    2'b00);
        check("abort_busy", bus_d2.busy, 1'b0);
        check("abort_data", bus_d2.data, 4'b0000);
        base = done_cnt[0];
        repeat (12) @(negedge clk);
        check("abort_no_done",   done_cnt[0] - base, 0);
        check("abort_data_hold", bus_d2.data, 4'b0000);
        bus_d2.start = 1'b1;
        @(negedge clk);
        bus_d2.start = 1'b0;
        t0 = cyc;
        wait_done(0, 20, "fresh");
        check("fresh_latency", cyc - t0, 8);
        check("fresh_data",    bus_d2.data, 4'b1101);
        repeat (3) @(negedge clk);

        // start held high, cont low: back-to-back scans every 9 cycles.
        bus_d2.start = 1'b1;
        wait_done(0, 20, "held_first");
        t0 = cyc;
        for (int r = 0; r < 2; r++) begin
            @(negedge clk);
            wait_done(0, 20, "held_next");
            check("held_period", cyc - t0, 9);
            t0 = cyc;
        end
        bus_d2.start = 1'b0;
        repeat (12) @(negedge clk);

        // Randomized phase, checked cycle by cycle by the monitor.
        for (int i = 0; i < 3000; i++) begin
            reset        = ($urandom_range(0, 63) == 0);
            bus_d2.start = ($urandom_range(0, 3) == 0);
            bus_d1.start = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 31) == 0) bus_d2.cont = ~bus_d2.cont;
            if ($urandom_range(0, 31) == 0) bus_d1.cont = ~bus_d1.cont;
            {a, b, c, d} = 4'($urandom);
            @(negedge clk);
        end
        reset = 1'b0;
        bus_d2.start = 1'b0; bus_d2.cont = 1'b0;
        bus_d1.start = 1'b0; bus_d1.cont = 1'b0;
        repeat (20) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
